// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back / write-allocate cache, one word per line,
// true-LRU replacement through per-way ages, handshaked backing-memory port.
module cache_assoc_wb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 13,
    parameter int WAYS   = 2,
    parameter int SETS   = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;

    state_t state, state_next;

    logic              valid_a [SETS][WAYS];
    logic              dirty_a [SETS][WAYS];
    logic [TAG_W-1:0]  tag_a   [SETS][WAYS];
    logic [DATA_W-1:0] data_a  [SETS][WAYS];
    logic [WAY_W-1:0]  age_a   [SETS][WAYS];

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [WAY_W-1:0]  vic_way;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag_q;
    logic              hit_any, inv_found, vic_dirty;
    logic [WAY_W-1:0]  hit_way, vic_sel, acc_way, acc_age;
    logic [WAY_W-1:0]  age_upd [WAYS];
    logic              do_hit, do_install, do_fill, respond;

    assign idx   = r_addr[IDX_W-1:0];
    assign tag_q = r_addr[ADDR_W-1:IDX_W];

    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vic_sel   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_a[idx][w] && tag_a[idx][w] == tag_q) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_a[idx][w]) begin
                inv_found = 1'b1;
                vic_sel   = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_a[idx][w] == WAY_W'(WAYS - 1)) vic_sel = WAY_W'(w);
            end
        end
    end

    assign vic_dirty  = valid_a[idx][vic_sel] && dirty_a[idx][vic_sel];
    assign acc_way    = (state == LOOKUP) ? (hit_any ? hit_way : vic_sel) : vic_way;
    assign do_hit     = (state == LOOKUP) && hit_any;
    assign do_install = r_we && (((state == LOOKUP) && !hit_any && !vic_dirty) ||
                                 ((state == WRITEBACK) && mem_ack));
    assign do_fill    = (state == FILL) && mem_ack;
    assign respond    = do_hit || do_install || do_fill;

    // Ages younger than the accessed way move up one; the accessed way becomes youngest.
    always_comb begin
        acc_age = age_a[idx][acc_way];
        for (int unsigned w = 0; w < WAYS; w++) begin
            age_upd[w] = (age_a[idx][w] < acc_age) ? age_a[idx][w] + 1'b1 : age_a[idx][w];
        end
        age_upd[acc_way] = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req_valid) state_next = LOOKUP;
            LOOKUP: begin
                if (hit_any)        state_next = IDLE;
                else if (vic_dirty) state_next = WRITEBACK;
                else if (!r_we)     state_next = FILL;
                else                state_next = IDLE;
            end
            WRITEBACK: if (mem_ack) state_next = r_we ? IDLE : FILL;
            FILL:      if (mem_ack) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_req   = (state == WRITEBACK) || (state == FILL);
        mem_we    = (state == WRITEBACK);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == WRITEBACK) begin
            mem_addr  = {tag_a[idx][vic_way], idx};
            mem_wdata = data_a[idx][vic_way];
        end else if (state == FILL) begin
            mem_addr  = r_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_a[s][w] <= 1'b0;
                    dirty_a[s][w] <= 1'b0;
                    tag_a[s][w]   <= '0;
                    data_a[s][w]  <= '0;
                    age_a[s][w]   <= WAY_W'(w);
                end
            end
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            vic_way    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            hit        <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            resp_valid <= respond;
            if (state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (state == LOOKUP && !hit_any) vic_way <= vic_sel;
            if (do_hit && r_we) begin
                data_a[idx][hit_way]  <= r_wdata;
                dirty_a[idx][hit_way] <= 1'b1;
            end
            if (do_install) begin
                valid_a[idx][acc_way] <= 1'b1;
                dirty_a[idx][acc_way] <= 1'b1;
                tag_a[idx][acc_way]   <= tag_q;
                data_a[idx][acc_way]  <= r_wdata;
            end
            if (do_fill) begin
                valid_a[idx][acc_way] <= 1'b1;
                dirty_a[idx][acc_way] <= 1'b0;
                tag_a[idx][acc_way]   <= tag_q;
                data_a[idx][acc_way]  <= mem_rdata;
            end
            if (respond) begin
                for (int unsigned w = 0; w < WAYS; w++) age_a[idx][w] <= age_upd[w];
                hit       <= do_hit;
                resp_data <= do_fill ? mem_rdata : (r_we ? r_wdata : data_a[idx][hit_way]);
                if (do_hit) begin
                    if (hit_count != '1) hit_count <= hit_count + 1'b1;
                end else begin
                    if (miss_count != '1) miss_count <= miss_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_assoc_wb.sv
// Scoreboard bench for cache_assoc_wb: a recency-list cache model predicts every
// response and write-back; a memory responder with optional wait states serves the DUT.
module tb_cache_assoc_wb;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 13;
    localparam int WAYS    = 2;
    localparam int SETS    = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 2**CNT_W - 1;
    localparam int DMASK   = 2**DATA_W - 1;
    localparam int MEMSZ   = 2**ADDR_W;

    logic              clock, reset, req_valid, req_we, req_ready, resp_valid, hit;
    logic [ADDR_W-1:0] req_addr, mem_addr;
    logic [DATA_W-1:0] req_wdata, resp_data, mem_wdata, mem_rdata;
    logic              mem_req, mem_we, mem_ack;
    logic [CNT_W-1:0]  hit_count, miss_count;

    cache_assoc_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .hit(hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int data; bit hit; int hc; int mc; } exp_t;
    typedef struct { int addr; int data; } wb_t;
    exp_t sbq[$];
    wb_t  wbq[$];

    // Reference model: each set is a list of lines ordered most- to least-recently used.
    int m_n [SETS];
    int m_tag [SETS][WAYS];
    int m_data [SETS][WAYS];
    bit m_dirty [SETS][WAYS];
    int mem_model [MEMSZ];
    logic [DATA_W-1:0] mem_arr [MEMSZ];
    int m_hc, m_mc;

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) m_n[s] = 0;
        m_hc = 0;
        m_mc = 0;
    endfunction

    function automatic void model_access(input bit we, input int addr, input int wdata,
                                         output int edata, output bit ehit);
        int s, t, k, ld;
        bit ldirty;
        wb_t wb;
        s = addr % SETS;
        t = addr / SETS;
        k = -1;
        for (int i = 0; i < m_n[s]; i++) if (m_tag[s][i] == t) k = i;
        if (k >= 0) begin
            ehit = 1;
            ld = we ? wdata : m_data[s][k];
            ldirty = we ? 1'b1 : m_dirty[s][k];
            for (int i = k; i < m_n[s] - 1; i++) begin
                m_tag[s][i] = m_tag[s][i+1];
                m_data[s][i] = m_data[s][i+1];
                m_dirty[s][i] = m_dirty[s][i+1];
            end
            m_n[s]--;
            if (m_hc < CNT_MAX) m_hc++;
        end else begin
            ehit = 0;
            if (m_n[s] == WAYS) begin
                if (m_dirty[s][WAYS-1]) begin
                    wb.addr = m_tag[s][WAYS-1] * SETS + s;
                    wb.data = m_data[s][WAYS-1];
                    wbq.push_back(wb);
                    mem_model[wb.addr] = wb.data;
                end
                m_n[s]--;
            end
            ld = we ? wdata : mem_model[addr];
            ldirty = we;
            if (m_mc < CNT_MAX) m_mc++;
        end
        for (int i = m_n[s]; i > 0; i--) begin
            m_tag[s][i] = m_tag[s][i-1];
            m_data[s][i] = m_data[s][i-1];
            m_dirty[s][i] = m_dirty[s][i-1];
        end
        m_tag[s][0] = t;
        m_data[s][0] = ld;
        m_dirty[s][0] = ldirty;
        m_n[s]++;
        edata = ld;
    endfunction

    // Memory responder.
    bit hold_ack = 0, busy = 0;
    int wait_max = 0, wcnt = 0, mem_cyc = 0, wr_cnt = 0;
    int last_rd_addr = -1, last_wr_addr = -1, last_wr_data = -1;

    initial begin
        wb_t w;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (mem_req === 1'b1) mem_cyc++;
            if (mem_req === 1'b1 && !(hold_ack && !mem_we)) begin
                if (!busy) begin
                    busy = 1;
                    wcnt = $urandom_range(0, wait_max);
                end
                if (wcnt == 0) begin
                    mem_ack = 1'b1;
                    busy = 0;
                    if (mem_we) begin
                        wr_cnt++;
                        last_wr_addr = int'(mem_addr);
                        last_wr_data = int'(mem_wdata);
                        mem_arr[mem_addr] = mem_wdata;
                        if (wbq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_writeback: got addr %0h data %0h expected none", mem_addr, mem_wdata);
                        end else begin
                            w = wbq.pop_front();
                            chk("wb_addr", 32'(mem_addr), w.addr);
                            chk("wb_data", 32'(mem_wdata), w.data);
                        end
                    end else begin
                        last_rd_addr = int'(mem_addr);
                        mem_rdata = mem_arr[mem_addr];
                    end
                end else begin
                    mem_ack = 1'b0;
                    wcnt--;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Response monitor.
    int resp_cnt = 0, resp_cyc = 0, acc_cyc = 0;
    always @(negedge clock) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            resp_cnt++;
            resp_cyc = cyc;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_resp: got data %0h hit %0b expected no response", resp_data, hit);
            end else begin
                e = sbq.pop_front();
                chk("resp_data", 32'(resp_data), e.data);
                chk("resp_hit", 32'(hit), 32'(e.hit));
                chk("hit_count", 32'(hit_count), e.hc);
                chk("miss_count", 32'(miss_count), e.mc);
            end
        end
    end

    task automatic issue(input bit we, input int addr, input int wdata);
        int n;
        exp_t e;
        int ed;
        bit eh;
        n = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk("ready_wait", 32'(req_ready), 1);
            return;
        end
        req_valid = 1'b1;
        req_we = we;
        req_addr = ADDR_W'(addr);
        req_wdata = DATA_W'(wdata);
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
        model_access(we, addr, wdata & DMASK, ed, eh);
        e.data = ed;
        e.hit = eh;
        e.hc = m_hc;
        e.mc = m_mc;
        sbq.push_back(e);
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("resp_wait", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic do_req(input bit we, input int addr, input int wdata);
        issue(we, addr, wdata);
        wait_resp();
    endtask

    task automatic wait_mem_req(input string name);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(mem_req), 1);
    endtask

    task automatic release_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        sbq.delete();
        wbq.delete();
        busy = 0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        release_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mc0, r0, w0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < MEMSZ; i++) begin
            mem_model[i] = $urandom & DMASK;
            mem_arr[i] = DATA_W'(mem_model[i]);
        end
        mem_model[5] = 'h0A3;
        mem_arr[5] = 13'h0A3;
        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_counts", 32'({hit_count, miss_count}), 0);
        chk("rst_mem", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 0);
        release_reset();

        // Read miss then hit on addr 5, zero-wait memory.
        mc0 = mem_cyc;
        do_req(0, 5, 0);
        chk("t1_fill_addr", last_rd_addr, 5);
        chk("t1_mem_cycles", mem_cyc - mc0, 1);
        chk("t1_miss_latency", resp_cyc - acc_cyc, 2);
        mc0 = mem_cyc;
        do_req(0, 5, 0);
        chk("t1_hit_no_mem", mem_cyc - mc0, 0);
        chk("t1_hit_latency", resp_cyc - acc_cyc, 1);
        chk("t1_hit_count", 32'(hit_count), 1);

        // Write miss into an empty set: no memory traffic, then read hit.
        apply_reset();
        mc0 = mem_cyc;
        do_req(1, 1, 'h1234);
        chk("t2_no_mem", mem_cyc - mc0, 0);
        chk("t2_latency", resp_cyc - acc_cyc, 1);
        do_req(0, 1, 0);

        // LRU victim selection with dirty write-back.
        apply_reset();
        do_req(1, 1, 'h111);
        do_req(1, 5, 'h555);
        do_req(0, 1, 0);
        w0 = wr_cnt;
        do_req(1, 9, 'h999);
        chk("t3_wb_count", wr_cnt - w0, 1);
        chk("t3_wb_addr", last_wr_addr, 5);
        chk("t3_wb_data", last_wr_data, 'h555);
        do_req(0, 1, 0);
        do_req(0, 5, 0);

        // Wait states during FILL with an ignored request pulse.
        hold_ack = 1;
        r0 = resp_cnt;
        issue(0, 2, 0);
        @(negedge clock);
        wait_mem_req("t4_fill_start");
        for (int i = 0; i < 3; i++) begin
            chk("t4_mem_req", 32'(mem_req), 1);
            chk("t4_mem_addr", 32'(mem_addr), 2);
            chk("t4_req_ready", 32'(req_ready), 0);
            if (i == 0) begin
                req_valid = 1'b1;
                req_we = 1'b1;
                req_addr = 7;
                req_wdata = 'h77;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clock);
        end
        hold_ack = 0;
        wait_resp();
        repeat (4) @(negedge clock);
        chk("t4_one_resp", resp_cnt - r0, 1);

        // Asynchronous reset in the middle of a FILL.
        do_req(0, 5, 0);
        hold_ack = 1;
        issue(0, 3, 0);
        @(negedge clock);
        wait_mem_req("t5_fill_start");
        #2;
        reset = 1'b1;
        #1;
        chk("t5_mem_req_async", 32'(mem_req), 0);
        chk("t5_resp_valid", 32'(resp_valid), 0);
        release_reset();
        hold_ack = 0;
        chk("t5_req_ready", 32'(req_ready), 1);
        chk("t5_counts", 32'({hit_count, miss_count}), 0);
        do_req(0, 5, 0);
        chk("t5_addr5_miss", 32'(hit), 0);

        // Hit counter saturation.
        for (int i = 0; i < 300; i++) do_req(0, 5, 0);
        chk("t6_hit_sat", 32'(hit_count), CNT_MAX);
        chk("t6_miss_kept", 32'(miss_count), 1);

        // Random traffic with random memory wait states.
        wait_max = 3;
        for (int i = 0; i < 200; i++) begin
            do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, MEMSZ - 1)), int'($urandom & DMASK));
        end
        repeat (3) @(negedge clock);
        chk("wb_queue_drained", wbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
